// File: rtl/trivium_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : trivium_stream_ctrl
// Description : Host-side controller for a Trivium keystream core. Loads the
//               80-bit key and IV byte-serially from an 8-bit bus. Holds the
//               core in reset while loading, runs the warm-up rounds, then
//               packs keystream bits LSB-first into bytes delivered over a
//               valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module trivium_stream_ctrl #(
   parameter int unsigned WARMUP = 1152
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [7:0]  data_in_i,
   input  logic        load_key_i,
   input  logic        load_iv_i,
   input  logic        start_i,
   input  logic        stop_i,
   output logic [79:0] key_out_o,
   output logic [79:0] iv_out_o,
   output logic        core_rst_n_o,
   output logic        core_en_o,
   input  logic        ks_bit_in_i,
   output logic [7:0]  ks_byte_o,
   output logic        ks_valid_o,
   input  logic        ks_ready_i,
   output logic        busy_o
);

   // Number of bytes that make up a complete key or IV.
   localparam logic [3:0]  c_full_cnt  = 4'd10;
   // Value of the warm-up counter on the last discarded core step.
   localparam logic [15:0] c_warm_last = 16'((WARMUP == 0) ? 0 : WARMUP - 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_CORE_RST = 2'd1,
      S_WARMUP   = 2'd2,
      S_RUN      = 2'd3
   } state_e;

   state_e      state_q;
   logic [79:0] key_q,     key_d;
   logic [79:0] iv_q,      iv_d;
   logic [3:0]  key_cnt_q, key_cnt_d;
   logic [3:0]  iv_cnt_q,  iv_cnt_d;
   logic [15:0] warm_cnt_q;
   logic [2:0]  bit_cnt_q;
   logic [6:0]  sr_q;
   logic [7:0]  ks_byte_q;
   logic        ks_valid_q;
   logic        core_rst_n_q;
   logic        busy_q;

   logic        w_idle;
   logic        w_stall;
   logic        w_core_en;
   logic        w_start_ok;

   assign w_idle     = (state_q == S_IDLE);
   // A full output byte that nobody is taking freezes the core so no bit is lost.
   assign w_stall    = ks_valid_q & ~ks_ready_i;
   assign w_core_en  = (state_q == S_WARMUP) | ((state_q == S_RUN) & ~w_stall);
   // Start looks at the counts before any load in the same cycle.
   assign w_start_ok = start_i & (key_cnt_q == c_full_cnt) & (iv_cnt_q == c_full_cnt);

   // Next key/IV contents: shift a byte in from the LSB end while idle.
   always_comb begin
      key_d     = key_q;
      iv_d      = iv_q;
      key_cnt_d = key_cnt_q;
      iv_cnt_d  = iv_cnt_q;
      if (w_idle && load_key_i) begin
         key_d     = {key_q[71:0], data_in_i};
         key_cnt_d = (key_cnt_q == c_full_cnt) ? key_cnt_q : key_cnt_q + 4'd1;
      end
      if (w_idle && load_iv_i) begin
         iv_d     = {iv_q[71:0], data_in_i};
         iv_cnt_d = (iv_cnt_q == c_full_cnt) ? iv_cnt_q : iv_cnt_q + 4'd1;
      end
   end

   // Key/IV registers and their byte counters; only rst_ni clears them.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         key_q     <= '0;
         iv_q      <= '0;
         key_cnt_q <= '0;
         iv_cnt_q  <= '0;
      end else begin
         key_q     <= key_d;
         iv_q      <= iv_d;
         key_cnt_q <= key_cnt_d;
         iv_cnt_q  <= iv_cnt_d;
      end
   end

   // Session state machine with registered core-reset, busy and byte outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         warm_cnt_q   <= '0;
         bit_cnt_q    <= '0;
         sr_q         <= '0;
         ks_byte_q    <= '0;
         ks_valid_q   <= 1'b0;
         core_rst_n_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (w_start_ok) begin
                  state_q <= S_CORE_RST;
                  busy_q  <= 1'b1;
               end
            end
            S_CORE_RST: begin
               // The core sees exactly one reset cycle with the fresh key/IV.
               warm_cnt_q   <= '0;
               bit_cnt_q    <= '0;
               sr_q         <= '0;
               core_rst_n_q <= 1'b1;
               if (WARMUP == 0) begin
                  state_q <= S_RUN;
               end else begin
                  state_q <= S_WARMUP;
               end
            end
            S_WARMUP: begin
               // Core output is ignored; just count the discarded steps.
               if (warm_cnt_q == c_warm_last) begin
                  state_q <= S_RUN;
               end else begin
                  warm_cnt_q <= warm_cnt_q + 16'd1;
               end
            end
            S_RUN: begin
               if (ks_valid_q && ks_ready_i) begin
                  ks_valid_q <= 1'b0;
               end
               if (w_core_en) begin
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     // Eighth bit completes the byte; it overrides a same-cycle take.
                     ks_byte_q  <= {ks_bit_in_i, sr_q};
                     ks_valid_q <= 1'b1;
                     sr_q       <= '0;
                  end else begin
                     // Right shift so the first bit ends up in bit 0.
                     sr_q <= {ks_bit_in_i, sr_q[6:1]};
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase

         // Abort wins over everything else: drop the partial byte, keep key/IV.
         if (stop_i && !w_idle) begin
            state_q      <= S_IDLE;
            warm_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            sr_q         <= '0;
            ks_valid_q   <= 1'b0;
            core_rst_n_q <= 1'b0;
            busy_q       <= 1'b0;
         end
      end
   end

   assign key_out_o    = key_q;
   assign iv_out_o     = iv_q;
   assign core_rst_n_o = core_rst_n_q;
   assign core_en_o    = w_core_en;
   assign ks_byte_o    = ks_byte_q;
   assign ks_valid_o   = ks_valid_q;
   assign busy_o       = busy_q;

endmodule
`default_nettype wire
